alu_req_ctrl: RTL and testbench
===============================

# alu_req_ctrl

Request-side controller that drives `alu_core`. It accepts operand/opcode requests over a valid/ready handshake and holds them stable on the ALU input ports. It then waits out the ALU's registered latency, captures the 8-bit result, and returns it with the request tag over a valid/ready response channel. It sits between a command source (CPU bus bridge or test sequencer) and `alu_core`, and keeps operation and divide-by-zero statistics.

## Interface
- `DW`, default 4: operand width (matches `alu_core` a/b).
- `RW`, default 8: result width (matches `alu_core` result).
- `TAGW`, default 4: request tag width.
- `ALU_LATENCY`, default 1: rising edges from ALU input change to valid `alu_result`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_a`, `req_b`  in  DW each  operands.
- `req_op`  in  2  00 add, 01 sub, 10 mul, 11 div.
- `req_tag`  in  TAGW  opaque tag, returned with the response.
- `alu_a`, `alu_b`  out  DW each  to `alu_core` a/b.
- `alu_op`  out  2  to `alu_core` op.
- `alu_result`  in  RW  from `alu_core` result.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_result`  out  RW  captured ALU result.
- `rsp_tag`  out  TAGW  tag of the request.
- `rsp_dz`  out  1  request was a divide by zero.
- `op_count`  out  16  completed responses, wraps.
- `dz_count`  out  8  completed divide-by-zero responses, saturates at 255.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - WAIT: latency countdown, `req_ready`=0.
  - RESP: `rsp_valid`=1.
- IDLE, `req_valid`&&`req_ready`: latch a/b/op/tag into internal registers. Load the wait counter with `ALU_LATENCY`. Go to WAIT.
- `alu_a`/`alu_b`/`alu_op` are driven only from the latched registers. They are stable from the edge after acceptance until the next acceptance and never change during WAIT or RESP.
- WAIT: decrement the counter each edge. At the edge where the counter is 0:
  - capture `alu_result` into `rsp_result`;
  - set `rsp_tag` from the latched tag;
  - set `rsp_dz` = (latched op==2'b11 && latched b==0);
  - go to RESP.
- `rsp_dz` is decoded from the operands, never from the result value. Sub wrap (e.g. 0-1 = 8'hFF) must not flag.
- RESP: hold `rsp_valid` and all rsp_* fields stable until `rsp_ready`. `req_ready` = `rsp_ready` (combinational), so a new request is accepted on the same edge as the response handshake.
- On the RESP handshake:
  - new request also accepted: latch it and go to WAIT;
  - no new request: go to IDLE.
- Counters update on each RESP handshake:
  - `op_count` +1, wraps 65535→0;
  - `dz_count` +1 if `rsp_dz`, held at 255 once reached.
- `req_*` inputs are ignored whenever `req_ready`=0.

## Timing
- Reset (`rst_n`=0, asynchronous, any state, including mid-WAIT or mid-RESP):
  - state = IDLE;
  - `req_ready`=1 after reset;
  - `rsp_valid`=0, `rsp_result`=0, `rsp_tag`=0, `rsp_dz`=0;
  - `alu_a`=`alu_b`=0, `alu_op`=00;
  - `op_count`=0, `dz_count`=0.
  - An in-flight request is dropped with no response.
- Acceptance edge E0: ALU inputs update after E0. With `ALU_LATENCY`=1, `alu_core` registers at E1, the block captures at E2, and `rsp_valid`=1 after E2. Latency = `ALU_LATENCY`+1 cycles.
- Back-to-back with `rsp_ready` held 1: one op every `ALU_LATENCY`+2 cycles.
- `rsp_valid` never deasserts without a handshake, except on reset.

## Test plan
- Reset, then req a=5 b=3 op=00 tag=1 -> `rsp_valid` 2 cycles after accept, result=8, tag=1, dz=0, `op_count`=1.
- Sequence sub 6-2, mul 3*3, div 4/2 with `rsp_ready`=1 -> results 4, 9, 2 in order. Each new request is accepted on its predecessor's response-handshake edge; `alu_*` stable between accepts.
- Div a=5 b=0 -> result=8'hFF, dz=1, `dz_count`=1. Then sub a=0 b=1 -> result=8'hFF, dz=0, `dz_count` still 1.
- Hold `rsp_ready`=0 for 5 cycles with `req_valid`=1 and changing req_* -> `req_ready`=0, rsp_* and `alu_*` unchanged. Raise `rsp_ready` -> handshake and the pending request is accepted on the same edge.
- Assert `rst_n`=0 asynchronously mid-WAIT -> all outputs at reset values immediately, no response emitted. After release, a new add 1+1 returns 2 with `op_count`=1.
- 256 div-by-zero requests -> `dz_count` saturates at 255; `op_count`=256.

Source files
------------

// File: rtl/alu_req_ctrl.sv
// Request-side controller for alu_core: accepts a request, holds the ALU
// inputs stable, waits out the ALU latency and returns the result with its tag.
module alu_req_ctrl #(
  parameter int DW          = 4,
  parameter int RW          = 8,
  parameter int TAGW        = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [DW-1:0]   req_a,
  input  logic [DW-1:0]   req_b,
  input  logic [1:0]      req_op,
  input  logic [TAGW-1:0] req_tag,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [1:0]      alu_op,
  input  logic [RW-1:0]   alu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RW-1:0]   rsp_result,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_dz,
  output logic [15:0]     op_count,
  output logic [7:0]      dz_count
);

  localparam int CW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [RW-1:0]   rsp_result_q, rsp_result_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic            rsp_dz_q, rsp_dz_d;
  logic [15:0]     op_count_q, op_count_d;
  logic [7:0]      dz_count_q, dz_count_d;

  logic accept;
  logic rsp_hs;

  // In RESP the ready is a pass-through of rsp_ready so a new request lands
  // on the same edge as the response handshake.
  assign req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
  assign rsp_valid = (state_q == S_RESP);
  assign accept    = req_valid && req_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    tag_d        = tag_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_dz_d     = rsp_dz_q;
    op_count_d   = op_count_q;
    dz_count_d   = dz_count_q;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_result_d = alu_result;
          rsp_tag_d    = tag_q;
          // Decoded from the operands: a wrapping subtract can also yield all-ones.
          rsp_dz_d     = (op_q == 2'b11) && (b_q == '0);
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_hs) begin
          op_count_d = op_count_q + 16'd1;
          if (rsp_dz_q && (dz_count_q != 8'hFF)) begin
            dz_count_d = dz_count_q + 8'd1;
          end
          state_d = S_IDLE;
        end
      end
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      a_d     = req_a;
      b_d     = req_b;
      op_d    = req_op;
      tag_d   = req_tag;
      cnt_d   = CW'(ALU_LATENCY);
      state_d = S_WAIT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_dz_q     <= 1'b0;
      op_count_q   <= '0;
      dz_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_dz_q     <= rsp_dz_d;
      op_count_q   <= op_count_d;
      dz_count_q   <= dz_count_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_dz     = rsp_dz_q;
  assign op_count   = op_count_q;
  assign dz_count   = dz_count_q;

endmodule

// File: tb/tb_alu_req_ctrl.sv
// Bench for alu_req_ctrl: a registered alu_core stand-in plus a
// transaction-level model of the request/response timing and statistics.
module tb_alu_req_ctrl;

  localparam int L = 1;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a, req_b;
  logic [1:0] req_op;
  logic [3:0] req_tag;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_tag;
  logic       rsp_dz;
  logic [15:0] op_count;
  logic [7:0]  dz_count;

  alu_req_ctrl #(.DW(4), .RW(8), .TAGW(4), .ALU_LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_dz     (rsp_dz),
    .op_count   (op_count),
    .dz_count   (dz_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return 8'(a) + 8'(b);
      2'b01:   return 8'(a) - 8'(b);
      2'b10:   return 8'(a) * 8'(b);
      default: return (b == 4'd0) ? 8'hFF : 8'(a / b);
    endcase
  endfunction

  // alu_core stand-in with one registered stage
  always_ff @(posedge clk) alu_result <= alu_ref(alu_a, alu_b, alu_op);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: one request in flight, response due L+1 edges after accept.
  bit         m_out;
  int         m_age;
  logic [3:0] m_a, m_b, m_tag;
  logic [1:0] m_op;
  int         m_opc, m_dzc;
  bit         last_acc;

  function automatic bit m_rsp_valid();
    return m_out && (m_age >= L + 1);
  endfunction

  function automatic bit m_dz();
    return (m_op == 2'b11) && (m_b == 4'd0);
  endfunction

  task automatic model_reset();
    m_out = 0; m_age = 0;
    m_a = '0; m_b = '0; m_op = '0; m_tag = '0;
    m_opc = 0; m_dzc = 0;
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_dz", rsp_dz, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_op_count", op_count, 0);
    check("rst_dz_count", dz_count, 0);
  endtask

  // One clock: check outputs mid-cycle, then advance the model over the edge.
  task automatic step();
    bit rv, hs, acc;
    @(negedge clk);
    rv = m_rsp_valid();
    check("rsp_valid", rsp_valid, rv);
    check("req_ready", req_ready, (!m_out || (rv && rsp_ready)) ? 1 : 0);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_op", alu_op, m_op);
    check("op_count", op_count, 32'(m_opc));
    check("dz_count", dz_count, 32'(m_dzc));
    if (rv) begin
      check("rsp_result", rsp_result, alu_ref(m_a, m_b, m_op));
      check("rsp_tag", rsp_tag, m_tag);
      check("rsp_dz", rsp_dz, m_dz());
    end
    hs  = rv && rsp_ready;
    acc = req_valid && (!m_out || hs);
    @(posedge clk);
    if (hs) begin
      m_opc = (m_opc + 1) % 65536;
      if (m_dz() && m_dzc < 255) m_dzc++;
      m_out = 0;
    end
    if (acc) begin
      m_a = req_a; m_b = req_b; m_op = req_op; m_tag = req_tag;
      m_out = 1; m_age = 0;
    end else if (m_out) begin
      m_age++;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic do_reset();
    req_valid = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic [3:0] tag);
    int n;
    req_valid = 1; req_a = a; req_b = b; req_op = op; req_tag = tag;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) check("issue_timeout", 0, 1);
    req_valid = 0;
  endtask

  task automatic drain(input int n);
    req_valid = 0;
    rsp_ready = 1;
    repeat (n) step();
  endtask

  initial begin
    rst_n = 0; req_valid = 0; rsp_ready = 0;
    req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    model_reset();
    #1 check_reset_vals();
    do_reset();
    check_reset_vals();

    // single add
    rsp_ready = 1;
    issue(4'd5, 4'd3, 2'b00, 4'd1);
    drain(4);
    check("add_op_count", op_count, 1);

    // back-to-back sub/mul/div
    issue(4'd6, 4'd2, 2'b01, 4'd2);
    issue(4'd3, 4'd3, 2'b10, 4'd3);
    issue(4'd4, 4'd2, 2'b11, 4'd4);
    drain(4);

    // divide by zero, then wrapping subtract that must not flag
    issue(4'd5, 4'd0, 2'b11, 4'd5);
    drain(4);
    check("dz_after_div0", dz_count, 1);
    issue(4'd0, 4'd1, 2'b01, 4'd6);
    drain(4);
    check("dz_after_sub_wrap", dz_count, 1);

    // consumer stalls while new requests are presented
    rsp_ready = 0;
    issue(4'd7, 4'd2, 2'b00, 4'd7);
    req_valid = 1;
    repeat (7) begin
      req_a = 4'($urandom); req_b = 4'($urandom);
      req_op = 2'($urandom); req_tag = 4'($urandom);
      step();
    end
    req_a = 4'd9; req_b = 4'd4; req_op = 2'b01; req_tag = 4'd8;
    rsp_ready = 1;
    step();
    check("same_edge_accept", last_acc, 1);
    check("same_edge_alu_a", alu_a, 9);
    req_valid = 0;
    drain(4);

    // asynchronous reset while waiting on the ALU
    issue(4'd8, 4'd8, 2'b10, 4'd9);
    #2 rst_n = 0;
    #1 check_reset_vals();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    drain(3);
    issue(4'd1, 4'd1, 2'b00, 4'd10);
    drain(4);
    check("post_reset_op_count", op_count, 1);

    // dz_count saturation
    do_reset();
    rsp_ready = 1;
    for (int i = 0; i < 256; i++) issue(4'($urandom), 4'd0, 2'b11, 4'(i));
    drain(4);
    check("dz_saturated", dz_count, 255);
    check("op_count_256", op_count, 256);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_a = 4'($urandom); req_b = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
      req_op = 2'($urandom); req_tag = 4'($urandom);
      step();
    end
    drain(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
